macc_dot_sched: RTL and testbench

//  Round-robin scheduler sharing one pipelined macc2 multiply-accumulate unit between NREQ requesters.

---
 rtl/macc_dot_sched.sv | 154 +++++++++++++++
 tb/tb_macc_dot_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_dot_sched.sv
// Round-robin scheduler that time-shares one pipelined macc2 between NREQ requesters.
// Each grant runs a full dot product: clear, stream len operand pairs, drain, hand back the sum.
module macc_dot_sched #(
  parameter int NREQ     = 4,
  parameter int SIZEIN   = 16,
  parameter int SIZEOUT  = 40,
  parameter int MACC_LAT = 3,
  parameter int LENW     = 8,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LENW-1:0]      req_len,
  output logic [NREQ-1:0]           gnt,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [SIZEIN-1:0]         op_a,
  input  logic [SIZEIN-1:0]         op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [SIZEOUT-1:0] res_data,
  output logic                      res_ovf,
  output logic [IDW-1:0]            res_id,
  output logic                      busy,
  output logic                      m_ce,
  output logic                      m_rst,
  output logic [SIZEIN-1:0]         m_a,
  output logic [SIZEIN-1:0]         m_b,
  input  logic signed [SIZEOUT-1:0] m_accum,
  input  logic                      m_ovf
);

  localparam int CW = $clog2(MACC_LAT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MACC_LAT - 1);
  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RESULT} state_t;

  state_t                      state_reg, state_next;
  logic [IDW-1:0]              ptr_reg, id_reg, pick_idx;
  logic                        pick_found;
  logic [LENW-1:0]             len_reg;
  logic [CW-1:0]               cnt_reg;
  logic signed [SIZEOUT-1:0]   res_data_reg;
  logic                        res_ovf_reg;
  logic                        cnt_last;
  logic [LENW-1:0]             len_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_arr[gi] = req_len[gi*LENW +: LENW];
  end

  assign cnt_last = (cnt_reg == CNT_LAST);

  // Scan from the farthest candidate back to the pointer so the nearest set bit wins.
  always_comb begin
    logic [IDW:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDW + 1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    op_ready   = 1'b0;
    busy       = (state_reg != S_IDLE);
    m_ce       = 1'b0;
    m_rst      = 1'b0;
    m_a        = '0;
    m_b        = '0;
    if (state_reg != S_IDLE) gnt[id_reg] = 1'b1;
    case (state_reg)
      S_IDLE: if (pick_found) state_next = S_CLEAR;
      S_CLEAR: begin
        m_rst = 1'b1;
        m_ce  = 1'b1;
        if (cnt_last) state_next = (len_reg == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        op_ready = 1'b1;
        if (op_valid) begin
          m_ce = 1'b1;
          m_a  = op_a;
          m_b  = op_b;
          if (len_reg == LENW'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        m_ce = 1'b1;
        if (cnt_last) state_next = S_RESULT;
      end
      S_RESULT: if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // The MACC is held in clear while the scheduler itself is in reset.
    if (!rst_n) begin
      m_rst = 1'b1;
      m_ce  = 1'b0;
      m_a   = '0;
      m_b   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      id_reg       <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      res_data_reg <= '0;
      res_ovf_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (pick_found) begin
          id_reg      <= pick_idx;
          len_reg     <= len_arr[pick_idx];
          cnt_reg     <= '0;
          res_ovf_reg <= 1'b0;
        end
        S_CLEAR: cnt_reg <= cnt_last ? '0 : cnt_reg + 1'b1;
        S_STREAM: begin
          if (op_valid) len_reg <= len_reg - 1'b1;
          res_ovf_reg <= res_ovf_reg | m_ovf;
        end
        S_DRAIN: begin
          cnt_reg     <= cnt_last ? '0 : cnt_reg + 1'b1;
          res_ovf_reg <= res_ovf_reg | m_ovf;
          if (cnt_last) res_data_reg <= m_accum;
        end
        S_RESULT: if (res_ready) ptr_reg <= (id_reg == ID_LAST) ? '0 : id_reg + 1'b1;
        default: ;
      endcase
    end
  end

  assign res_valid = (state_reg == S_RESULT);
  assign res_data  = res_data_reg;
  assign res_ovf   = res_ovf_reg;
  assign res_id    = id_reg;

endmodule

// File: tb/tb_macc_dot_sched.sv
// Bench for macc_dot_sched paired with a behavioural macc2 pipeline; expected results
// come from plain dot-product arithmetic and a round-robin order model, checked by a monitor.
module tb_macc_dot_sched;
  localparam int NREQ = 4, SIZEIN = 16, SIZEOUT = 40, MACC_LAT = 3, LENW = 8, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n = 1'b0;
  logic [NREQ-1:0]           req;
  logic [NREQ*LENW-1:0]      req_len = '0;
  logic [NREQ-1:0]           gnt;
  logic                      op_valid = 1'b0, op_ready;
  logic [SIZEIN-1:0]         op_a = '0, op_b = '0;
  logic                      res_valid, res_ready = 1'b0;
  logic signed [SIZEOUT-1:0] res_data;
  logic                      res_ovf;
  logic [IDW-1:0]            res_id;
  logic                      busy, m_ce, m_rst, m_ovf;
  logic [SIZEIN-1:0]         m_a, m_b;
  logic signed [SIZEOUT-1:0] m_accum;

  macc_dot_sched #(.NREQ(NREQ), .SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .MACC_LAT(MACC_LAT), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .res_id(res_id), .busy(busy), .m_ce(m_ce), .m_rst(m_rst), .m_a(m_a), .m_b(m_b),
    .m_accum(m_accum), .m_ovf(m_ovf));

  // macc2 partner: operand register, product register, accumulator (3 ce-enabled stages)
  logic signed [SIZEIN-1:0]   ma_r = '0, mb_r = '0;
  logic signed [2*SIZEIN-1:0] mp_r = '0;
  logic signed [SIZEOUT-1:0]  acc_r = '0, mp_ext, acc_sum;
  logic                       add_ovf = 1'b0, force_ovf = 1'b0;
  assign mp_ext  = {{(SIZEOUT-2*SIZEIN){mp_r[2*SIZEIN-1]}}, mp_r};
  assign acc_sum = acc_r + mp_ext;
  always @(posedge clk) begin
    if (m_ce) begin
      if (m_rst) begin
        ma_r <= '0; mb_r <= '0; mp_r <= '0; acc_r <= '0; add_ovf <= 1'b0;
      end else begin
        ma_r    <= m_a;
        mb_r    <= m_b;
        mp_r    <= ma_r * mb_r;
        acc_r   <= acc_sum;
        add_ovf <= add_ovf | ((acc_r[SIZEOUT-1] == mp_ext[SIZEOUT-1]) && (acc_sum[SIZEOUT-1] != acc_r[SIZEOUT-1]));
      end
    end
  end
  assign m_accum = acc_r;
  assign m_ovf   = add_ovf | force_ovf;

  // Requester side: a bit stays requested until the monitor accepts that requester's result.
  logic [NREQ-1:0] req_on = '0, served_tog = '0, base_tog = '0;
  assign req = req_on & ~(served_tog ^ base_tog);

  typedef struct {int id; longint sum; bit ovf;} exp_t;
  exp_t exp_q[$];
  int   a_mem [NREQ][256];
  int   b_mem [NREQ][256];
  int   lens [NREQ];
  int   force_at [NREQ];
  bit   toggle_mode = 1'b0;
  int   stall_cycles = 0;
  int   model_ptr = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, 0);           check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0); check("rst_res_data", res_data, 0);
    check("rst_res_ovf", res_ovf, 0);   check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);         check("rst_m_rst", m_rst, 1);
    check("rst_m_ce", m_ce, 0);         check("rst_m_ab", {m_a, m_b}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_on = '0; op_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1; model_ptr = 0; base_tog = served_tog;
  endtask

  task automatic set_lens();
    for (int i = 0; i < NREQ; i++) req_len[i*LENW +: LENW] = LENW'(lens[i]);
  endtask

  task automatic stream_job(input int g, input int n, input bit check_drop);
    int k = 0, guard = 0, av, bv;
    bit phase = 1'b1;
    while (k < n && guard < 4*n + 100) begin
      @(negedge clk);
      guard++;
      av = a_mem[g][k]; bv = b_mem[g][k];
      op_a = av[SIZEIN-1:0]; op_b = bv[SIZEIN-1:0];
      op_valid = toggle_mode ? phase : 1'b1;
      phase = ~phase;
      force_ovf = 1'b0;
      if (op_valid && op_ready) begin
        if (k == force_at[g]) force_ovf = 1'b1;
        k++;
      end
    end
    if (k < n) timeout_fail("stream_timeout");
    if (check_drop) begin
      @(negedge clk);
      op_valid = 1'b0; force_ovf = 1'b0;
      if (n > 0) check("op_ready_drop", op_ready, 0);
    end
  endtask

  task automatic wait_gnt(input bit want_nonzero, input int budget, input string name);
    int t = 0;
    while (((gnt != 0) != want_nonzero) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if ((gnt != 0) != want_nonzero) timeout_fail(name);
  endtask

  // Predict the service order from the round-robin rule, queue expected sums, then serve each grant.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    int order[$];
    logic [NREQ-1:0] pend = mask;
    int p = model_ptr;
    exp_t e;
    while (pend != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (pend[(p + k) % NREQ]) begin
          order.push_back((p + k) % NREQ);
          pend[(p + k) % NREQ] = 1'b0;
          p = ((p + k) % NREQ + 1) % NREQ;
          break;
        end
      end
    end
    model_ptr = p;
    foreach (order[j]) begin
      e.id = order[j]; e.sum = 0;
      for (int k = 0; k < lens[e.id]; k++) e.sum += longint'(a_mem[e.id][k]) * longint'(b_mem[e.id][k]);
      e.ovf = (force_at[e.id] >= 0) && (force_at[e.id] < lens[e.id]);
      exp_q.push_back(e);
    end
    @(negedge clk);
    set_lens();
    base_tog = served_tog;
    req_on = mask;
    foreach (order[j]) begin
      wait_gnt(1'b1, 500, "gnt_timeout");
      check("gnt_onehot", gnt, longint'(1) << order[j]);
      check("busy_in_job", busy, 1);
      stream_job(order[j], lens[order[j]], 1'b1);
      wait_gnt(1'b0, 100 + stall_cycles, "job_end_timeout");
    end
    req_on = '0;
  endtask

  // Monitor: consumes results (with optional back-pressure) and compares against the queue.
  initial begin
    bit in_res = 1'b0;
    int wait_left = 0;
    longint snap_data = 0;
    int snap_id = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      res_ready = 1'b0;
      if (rst_n && res_valid) begin
        if (!in_res) begin
          in_res = 1'b1; snap_data = res_data; snap_id = res_id; wait_left = stall_cycles;
        end
        if (wait_left > 0) wait_left--;
        else begin
          res_ready = 1'b1;
          in_res = 1'b0;
          if (exp_q.size() == 0) timeout_fail("unexpected_result");
          else begin
            e = exp_q.pop_front();
            $display("result id=%0d data=%0d ovf=%0d (expected id=%0d data=%0d ovf=%0d)",
                     res_id, res_data, res_ovf, e.id, e.sum, e.ovf);
            check("res_id", res_id, e.id);
            check("res_data", res_data, e.sum);
            check("res_ovf", res_ovf, e.ovf);
            check("res_stable", {res_data == snap_data, res_id == IDW'(snap_id)}, 3);
            check("gnt_at_result", gnt, longint'(1) << e.id);
          end
          served_tog[res_id] = ~served_tog[res_id];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, ce_n, rdy_n;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin lens[i] = 0; force_at[i] = -1; end
    do_reset();

    // Single requester, expected 1*2+2*2+3*2+4*2 = 20
    lens[0] = 4;
    for (int k = 0; k < 4; k++) begin a_mem[0][k] = k + 1; b_mem[0][k] = 2; end
    run_batch(4'b0001);

    // All requesting from pointer 0, then 1010 after the pointer has wrapped
    do_reset();
    for (int i = 0; i < NREQ; i++) begin lens[i] = 1; a_mem[i][0] = i + 1; b_mem[i][0] = i + 1; end
    run_batch(4'b1111);
    run_batch(4'b1010);

    // Stalling operand source and result consumer, expected 269
    toggle_mode = 1'b1; stall_cycles = 5; lens[2] = 3;
    a_mem[2][0] = 5;   b_mem[2][0] = -7;
    a_mem[2][1] = 100; b_mem[2][1] = 3;
    a_mem[2][2] = -2;  b_mem[2][2] = -2;
    run_batch(4'b0100);
    toggle_mode = 1'b0; stall_cycles = 0;

    // Longest job with full-scale operands, then again with one forced overflow cycle
    lens[1] = 255;
    for (int k = 0; k < 255; k++) begin a_mem[1][k] = 32767; b_mem[1][k] = 32767; end
    run_batch(4'b0010);
    force_at[1] = 100;
    run_batch(4'b0010);
    force_at[1] = -1;

    // Zero-length job: latency 1 + 2*MACC_LAT, m_ce only in CLEAR/DRAIN, never op_ready
    lens[3] = 0;
    e.id = 3; e.sum = 0; e.ovf = 1'b0;
    exp_q.push_back(e);
    model_ptr = 0;
    @(negedge clk);
    set_lens();
    base_tog = served_tog;
    req_on = 4'b1000;
    n = 0; ce_n = 0; rdy_n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (!res_valid) begin ce_n += int'(m_ce); rdy_n += int'(op_ready); end
    end
    check("len0_latency", n, 1 + 2*MACC_LAT);
    check("len0_ce_cycles", ce_n, 2*MACC_LAT);
    check("len0_op_ready", rdy_n, 0);
    wait_gnt(1'b0, 100, "len0_end_timeout");
    req_on = '0;

    // Move the pointer to 2, abort a job on id 2 mid-stream; reset must return the pointer to 0
    lens[1] = 1; a_mem[1][0] = 3; b_mem[1][0] = -4;
    run_batch(4'b0010);
    lens[2] = 10;
    for (int k = 0; k < 10; k++) begin a_mem[2][k] = k; b_mem[2][k] = 1; end
    @(negedge clk);
    set_lens();
    base_tog = served_tog;
    req_on = 4'b0100;
    wait_gnt(1'b1, 50, "abort_gnt_timeout");
    stream_job(2, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; op_valid = 1'b0; req_on = '0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1; model_ptr = 0; base_tog = served_tog;
    lens[0] = 2; lens[3] = 2;
    for (int k = 0; k < 2; k++) begin
      a_mem[0][k] = k + 7; b_mem[0][k] = -3;
      a_mem[3][k] = -k - 1; b_mem[3][k] = 11;
    end
    run_batch(4'b1001);

    // Randomized batches
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        lens[i] = int'($urandom_range(0, 8));
        for (int k = 0; k < 8; k++) begin
          a_mem[i][k] = int'($urandom_range(0, 65535)) - 32768;
          b_mem[i][k] = int'($urandom_range(0, 65535)) - 32768;
        end
        force_at[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      end
      toggle_mode  = 1'($urandom_range(0, 1));
      stall_cycles = int'($urandom_range(0, 3));
      run_batch(4'($urandom_range(1, 15)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
